// File: rtl/sdp_ram_arb_pkg.sv
// Shared helpers for sdp_ram_arbiter: address-width calculation, requester limit and
// per-client slice selection from packed request buses.
package sdp_ram_arb_pkg;

  localparam int unsigned MaxRequesters = 8;
  localparam int unsigned MaxSliceBits  = 64;
  localparam int unsigned MaxBusBits    = MaxRequesters * MaxSliceBits;

  function automatic int unsigned addr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Returns bus[idx*w +: w], zero-extended; callers truncate to their field width.
  function automatic logic [MaxSliceBits-1:0] slice_bits(input logic [MaxBusBits-1:0] bus,
                                                         input int unsigned idx,
                                                         input int unsigned w);
    logic [MaxBusBits-1:0]   shifted;
    logic [MaxSliceBits-1:0] mask;
    shifted = bus >> (idx * w);
    mask    = (w >= MaxSliceBits) ? '1 : ((MaxSliceBits'(1) << w) - MaxSliceBits'(1));
    return shifted[MaxSliceBits-1:0] & mask;
  endfunction

  function automatic int unsigned onehot_idx(input logic [MaxRequesters-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxRequesters; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from last winner + 1;
// the last-grant pointer moves only when the caller reports the grant was taken.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand_idx;
  int            cand;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    gnt      = '0;
    win_idx  = last_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = int'(N); k >= 1; k--) begin
      cand     = (int'(last_q) + k) % int'(N);
      cand_idx = PW'(cand);
      if (req[cand_idx]) begin
        gnt           = '0;
        gnt[cand_idx] = 1'b1;
        win_idx       = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PW'(N - 1);
    end else if (advance) begin
      last_q <= win_idx;
    end
  end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Shares one simple dual-port RAM between REQUESTERS clients with independent write/read
// round-robin arbitration. Define SDP_ARB_BYPASS_EN to forward write data on collisions.
module sdp_ram_arbiter
  import sdp_ram_arb_pkg::*;
#(
  parameter int unsigned  WIDTH      = 8,
  parameter int unsigned  ENTRIES    = 256,
  parameter int unsigned  REQUESTERS = 2,
  localparam int unsigned AW         = addr_width(ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQUESTERS-1:0]      wr_valid,
  input  logic [REQUESTERS*AW-1:0]   wr_addr,
  input  logic [REQUESTERS*WIDTH-1:0] wr_data,
  output logic [REQUESTERS-1:0]      wr_ready,
  input  logic [REQUESTERS-1:0]      rd_valid,
  input  logic [REQUESTERS*AW-1:0]   rd_addr,
  output logic [REQUESTERS-1:0]      rd_ready,
  output logic [REQUESTERS-1:0]      rd_resp_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [AW-1:0]              ram_waddr,
  output logic [WIDTH-1:0]           ram_write_data,
  output logic                       ram_write_enable,
  output logic [AW-1:0]              ram_raddr,
  input  logic [WIDTH-1:0]           ram_read_data
);

  logic [REQUESTERS-1:0] wr_gnt;
  logic [REQUESTERS-1:0] rd_gnt;
  logic [REQUESTERS-1:0] resp_q;
  int unsigned           wr_idx;
  int unsigned           rd_idx;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  collision;

  rr_arbiter #(.N(REQUESTERS)) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_valid),
    .advance (wr_fire),
    .gnt     (wr_gnt)
  );

  // Read pointer advances only on an accepted read, so a stalled winner keeps priority.
  rr_arbiter #(.N(REQUESTERS)) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_valid),
    .advance (rd_fire),
    .gnt     (rd_gnt)
  );

  always_comb begin
    wr_idx           = onehot_idx(MaxRequesters'(wr_gnt));
    rd_idx           = onehot_idx(MaxRequesters'(rd_gnt));
    ram_waddr        = AW'(slice_bits(MaxBusBits'(wr_addr), wr_idx, AW));
    ram_write_data   = WIDTH'(slice_bits(MaxBusBits'(wr_data), wr_idx, WIDTH));
    ram_raddr        = AW'(slice_bits(MaxBusBits'(rd_addr), rd_idx, AW));
    wr_ready         = rst ? '0 : wr_gnt;
    wr_fire          = |wr_ready;
    ram_write_enable = wr_fire;
    collision        = wr_fire && (|rd_gnt) && (ram_raddr == ram_waddr);
`ifdef SDP_ARB_BYPASS_EN
    rd_ready         = rst ? '0 : rd_gnt;
`else
    rd_ready         = (rst || collision) ? '0 : rd_gnt;
`endif
    rd_fire          = |rd_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q <= '0;
    end else begin
      resp_q <= rd_valid & rd_ready;
    end
  end

  assign rd_resp_valid = resp_q;

`ifdef SDP_ARB_BYPASS_EN
  logic             byp_q;
  logic [WIDTH-1:0] byp_data_q;

  // RAM returns stale data on same-address read/write, so forward the write word instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_q      <= collision;
      byp_data_q <= ram_write_data;
    end
  end

  assign rd_data = byp_q ? byp_data_q : ram_read_data;
`else
  assign rd_data = ram_read_data;
`endif

endmodule
